// File: rtl/fetch_decode.sv
// fetch_decode: RV32I instruction fetch and decode front end.
// Owns the PC, fetches words over a req/ack handshake, decodes them into the
// core control word and issues it over a valid/ready handshake. Control-flow
// instructions stall fetch until the datapath resolves them.
// Optional build macro: FD_JAL_PREDICT_EN -- when defined, jal computes its
// target locally (pc + imm) and does not wait for the datapath to resolve it.

module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        cw_valid,
  input  logic        cw_ready,
  output logic [3:0]  instType,
  output logic [2:0]  fun3,
  output logic        fun7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc,
  output logic [31:0] imm,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_pc,
  output logic        illegal
);

`ifdef FD_JAL_PREDICT_EN
  localparam logic JAL_PREDICT = 1'b1;
`else
  localparam logic JAL_PREDICT = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] CLS_LOAD  = 4'd0;
  localparam logic [3:0] CLS_IMM   = 4'd1;
  localparam logic [3:0] CLS_STORE = 4'd2;
  localparam logic [3:0] CLS_REG   = 4'd3;
  localparam logic [3:0] CLS_LUI   = 4'd4;
  localparam logic [3:0] CLS_AUIPC = 4'd5;
  localparam logic [3:0] CLS_BRNCH = 4'd6;
  localparam logic [3:0] CLS_JALR  = 4'd7;
  localparam logic [3:0] CLS_JAL   = 4'd8;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic        cw_valid_q, cw_valid_d;
  logic        illegal_q, illegal_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  cls_q, cls_d;
  logic [2:0]  fun3_q, fun3_d;
  logic        fun7_q, fun7_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;

  logic        dec_legal_s;
  logic [3:0]  dec_cls_s;
  logic [2:0]  dec_fun3_s;
  logic        dec_fun7_s;
  logic [4:0]  dec_rd_s, dec_rs1_s, dec_rs2_s;
  logic [31:0] dec_imm_s;

  logic        fetch_done_s, handshake_s, resolve_done_s, to_resolve_s;
  logic        unused_s;

  // Target low bits are forced to zero, so they never reach any state.
  assign unused_s = ^resolve_pc[1:0];

  assign fetch_done_s   = (state_q == ST_FETCH) && imem_req_q && imem_ack;
  assign handshake_s    = (state_q == ST_ISSUE) && cw_valid_q && cw_ready;
  assign resolve_done_s = (state_q == ST_RESOLVE) && resolve_valid;
  assign to_resolve_s   = (cls_q == CLS_BRNCH) || (cls_q == CLS_JALR) ||
                          ((cls_q == CLS_JAL) && !JAL_PREDICT);

  // Classify the latched word by opcode; anything unknown is illegal.
  always_comb begin
    dec_legal_s = 1'b1;
    dec_cls_s   = CLS_LOAD;
    case (instr_q[6:0])
      7'b0000011: dec_cls_s = CLS_LOAD;
      7'b0010011: dec_cls_s = CLS_IMM;
      7'b0100011: dec_cls_s = CLS_STORE;
      7'b0110011: dec_cls_s = CLS_REG;
      7'b0110111: dec_cls_s = CLS_LUI;
      7'b0010111: dec_cls_s = CLS_AUIPC;
      7'b1100011: dec_cls_s = CLS_BRNCH;
      7'b1100111: dec_cls_s = CLS_JALR;
      7'b1101111: dec_cls_s = CLS_JAL;
      default: begin
        dec_legal_s = 1'b0;
        dec_cls_s   = CLS_LOAD;
      end
    endcase
  end

  // Extract register indices, function bits and immediate for the class.
  always_comb begin
    dec_rd_s   = instr_q[11:7];
    dec_rs1_s  = instr_q[19:15];
    dec_rs2_s  = 5'd0;
    dec_fun3_s = instr_q[14:12];
    dec_fun7_s = 1'b0;
    dec_imm_s  = 32'd0;
    case (dec_cls_s)
      CLS_LOAD, CLS_JALR: begin
        dec_imm_s = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      CLS_IMM: begin
        dec_imm_s = {{20{instr_q[31]}}, instr_q[31:20]};
        // Only the shift-immediate forms carry a meaningful instr[30].
        if ((instr_q[14:12] == 3'b001) || (instr_q[14:12] == 3'b101)) begin
          dec_fun7_s = instr_q[30];
        end else begin
          dec_fun7_s = 1'b0;
        end
      end
      CLS_STORE: begin
        dec_rd_s  = 5'd0;
        dec_rs2_s = instr_q[24:20];
        dec_imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      CLS_REG: begin
        dec_rs2_s  = instr_q[24:20];
        dec_fun7_s = instr_q[30];
      end
      CLS_LUI, CLS_AUIPC: begin
        // rs1 = x0 lets the datapath compute lui as x0 + imm.
        dec_rs1_s  = 5'd0;
        dec_fun3_s = 3'd0;
        dec_imm_s  = {instr_q[31:12], 12'd0};
      end
      CLS_BRNCH: begin
        dec_rd_s  = 5'd0;
        dec_rs2_s = instr_q[24:20];
        dec_imm_s = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};
      end
      CLS_JAL: begin
        dec_rs1_s  = 5'd0;
        dec_fun3_s = 3'd0;
        dec_imm_s  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                      instr_q[20], instr_q[30:21], 1'b0};
      end
      default: begin
        dec_rd_s   = 5'd0;
        dec_rs1_s  = 5'd0;
        dec_fun3_s = 3'd0;
      end
    endcase
  end

  // Next-state logic of the fetch/decode/issue sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_done_s) state_d = ST_DECODE;
        else              state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_legal_s) state_d = ST_ISSUE;
        else             state_d = ST_HALT;
      end
      ST_ISSUE: begin
        if (handshake_s) state_d = to_resolve_s ? ST_RESOLVE : ST_FETCH;
        else             state_d = ST_ISSUE;
      end
      ST_RESOLVE: begin
        if (resolve_done_s) state_d = ST_FETCH;
        else                state_d = ST_RESOLVE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase
  end

  // Handshake outputs follow the upcoming state so they come straight from flops.
  always_comb begin
    imem_req_d = (state_d == ST_FETCH);
    cw_valid_d = (state_d == ST_ISSUE);
    illegal_d  = illegal_q | (state_d == ST_HALT);
  end

  // State and handshake output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      imem_req_q <= 1'b0;
      cw_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      cw_valid_q <= cw_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  // PC update: sequential, locally predicted jal, or datapath-resolved target.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      ST_ISSUE: begin
        if (handshake_s && (cls_q == CLS_JAL) && JAL_PREDICT) pc_d = pc_q + imm_q;
        else if (handshake_s && !to_resolve_s)                pc_d = pc_q + 32'd4;
        else                                                  pc_d = pc_q;
      end
      ST_RESOLVE: begin
        if (resolve_done_s && resolve_taken) pc_d = {resolve_pc[31:2], 2'b00};
        else if (resolve_done_s)             pc_d = pc_q + 32'd4;
        else                                 pc_d = pc_q;
      end
      default: pc_d = pc_q;
    endcase
  end

  // Latch the fetched word and capture the decoded control word in DECODE.
  always_comb begin
    instr_d = fetch_done_s ? imem_rdata : instr_q;
    cls_d   = cls_q;
    fun3_d  = fun3_q;
    fun7_d  = fun7_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    if ((state_q == ST_DECODE) && dec_legal_s) begin
      cls_d  = dec_cls_s;
      fun3_d = dec_fun3_s;
      fun7_d = dec_fun7_s;
      rd_d   = dec_rd_s;
      rs1_d  = dec_rs1_s;
      rs2_d  = dec_rs2_s;
      imm_d  = dec_imm_s;
    end else if (state_q == ST_DECODE) begin
      cls_d  = 4'd0;
      fun3_d = 3'd0;
      fun7_d = 1'b0;
      rd_d   = 5'd0;
      rs1_d  = 5'd0;
      rs2_d  = 5'd0;
      imm_d  = 32'd0;
    end else begin
      cls_d  = cls_q;
    end
  end

  // PC, instruction and control word registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cls_q   <= 4'd0;
      fun3_q  <= 3'd0;
      fun7_q  <= 1'b0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cls_q   <= cls_d;
      fun3_q  <= fun3_d;
      fun7_q  <= fun7_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign cw_valid  = cw_valid_q;
  assign illegal   = illegal_q;
  assign instType  = cls_q;
  assign fun3      = fun3_q;
  assign fun7      = fun7_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign pc        = pc_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: directed scenarios plus randomized instruction
// streams checked against a behavioural decode/PC model.

module tb_fetch_decode;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OPC [0:8] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37,
                                       7'h17, 7'h63, 7'h67, 7'h6F};
`ifdef FD_JAL_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req, imem_ack, cw_valid, cw_ready, fun7, illegal;
  logic resolve_valid, resolve_taken;
  logic [31:0] imem_addr, imem_rdata, pc, imm, resolve_pc;
  logic [3:0] instType;
  logic [2:0] fun3;
  logic [4:0] rd, rs1, rs2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;
  logic [31:0] got_addr;
  int waited;
  logic [86:0] snap, exp_cw;

  wire [86:0] cw_now = {instType, fun3, fun7, rd, rs1, rs2, pc, imm};

  fetch_decode #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .instType(instType), .fun3(fun3), .fun7(fun7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_pc(resolve_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model: class index from the opcode table, -1 when unknown.
  function automatic int ref_class(input logic [6:0] op);
    for (int k = 0; k < 9; k++) if (OPC[k] == op) return k;
    return -1;
  endfunction

  // Reference model: expected control word {type,f3,f7,rd,rs1,rs2,pc,imm}.
  function automatic logic [86:0] ref_cw(input logic [31:0] w, input logic [31:0] p);
    int c, v;
    logic [31:0] im;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic f7;
    c = ref_class(w[6:0]);
    d = w[11:7]; s1 = w[19:15]; s2 = w[24:20]; f3 = w[14:12];
    if (c == 0 || c == 1 || c == 7) v = int'(w[30:20]) - (w[31] ? 2048 : 0);
    else if (c == 2) v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
    else if (c == 6) v = (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    else if (c == 8) v = int'(w[19:12]) * 4096 + (w[20] ? 2048 : 0) + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
    else v = 0;
    im = (c == 4 || c == 5) ? (w & 32'hFFFF_F000) : 32'(v);
    if (c == 2 || c == 6) d = 5'd0;
    if (c == 4 || c == 5 || c == 8) begin s1 = 5'd0; f3 = 3'd0; end
    if (!(c == 2 || c == 3 || c == 6)) s2 = 5'd0;
    f7 = (c == 3 || (c == 1 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))) ? w[30] : 1'b0;
    return {4'(c), f3, f7, d, s1, s2, p, im};
  endfunction

  // Wait (bounded) for a fetch request, then answer it after 'delay' cycles.
  task automatic fetch_word(input logic [31:0] word, input int delay,
                            output logic [31:0] addr, output int wt);
    wt = 0;
    addr = 32'hDEAD_BEEF;
    while (wt < 50) begin
      if (imem_req === 1'b1) break;
      @(negedge clk);
      wt++;
    end
    if (wt < 50) begin
      addr = imem_addr;
      repeat (delay) @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
    end else begin
      wt = 99;
    end
  endtask

  // Wait (bounded) for cw_valid; reports number of cycles waited.
  task automatic wait_valid(output int wt);
    wt = 0;
    while (wt < 20) begin
      if (cw_valid === 1'b1) break;
      @(negedge clk);
      wt++;
    end
  endtask

  task automatic accept();
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    resolve_valid = 1'b1;
    resolve_taken = taken;
    resolve_pc = tgt;
    @(negedge clk);
    resolve_valid = 1'b0;
    resolve_taken = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cw_valid); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    checks++; if (imem_addr !== TB_RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, TB_RESET_PC); end
    checks++; if (cw_now !== {23'd0, TB_RESET_PC, 32'd0}) begin errors++; $display("FAIL reset_cw: got %h expected %h", cw_now, {23'd0, TB_RESET_PC, 32'd0}); end
    imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b expected 1", imem_req); end
    model_pc = TB_RESET_PC;
  endtask

  task automatic test_addi();
    fetch_word(32'h0050_0093, 0, got_addr, waited);
    checks++; if (got_addr !== model_pc || waited !== 0) begin errors++; $display("FAIL addi_fetch: got addr %h wait %0d expected %h wait 0", got_addr, waited, model_pc); end
    wait_valid(waited);
    checks++; if (waited !== 1) begin errors++; $display("FAIL addi_latency: got %0d expected 1", waited); end
    exp_cw = ref_cw(32'h0050_0093, model_pc);
    checks++; if (cw_now !== exp_cw) begin errors++; $display("FAIL addi_cw: got %h expected %h", cw_now, exp_cw); end
    checks++; if ({instType, rd, rs1, fun3, imm} !== {4'd1, 5'd1, 5'd0, 3'd0, 32'd5}) begin errors++; $display("FAIL addi_fields: got %h expected %h", {instType, rd, rs1, fun3, imm}, {4'd1, 5'd1, 5'd0, 3'd0, 32'd5}); end
    accept();
    model_pc = model_pc + 32'd4;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL addi_next: got req %b addr %h expected 1 00000004", imem_req, imem_addr); end
  endtask

  task automatic test_store_stall();
    fetch_word(32'h0020_A423, 0, got_addr, waited);
    checks++; if (got_addr !== model_pc || waited !== 0) begin errors++; $display("FAIL sw_fetch: got addr %h wait %0d expected %h wait 0", got_addr, waited, model_pc); end
    wait_valid(waited);
    exp_cw = ref_cw(32'h0020_A423, model_pc);
    checks++; if (cw_now !== exp_cw) begin errors++; $display("FAIL sw_cw: got %h expected %h", cw_now, exp_cw); end
    checks++; if ({instType, rs1, rs2, rd, imm} !== {4'd2, 5'd1, 5'd2, 5'd0, 32'd8}) begin errors++; $display("FAIL sw_fields: got %h expected %h", {instType, rs1, rs2, rd, imm}, {4'd2, 5'd1, 5'd2, 5'd0, 32'd8}); end
    snap = cw_now;
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (cw_now !== snap || cw_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL sw_stall: got cw %h valid %b req %b expected %h 1 0", cw_now, cw_valid, imem_req, snap); end
    end
    imem_ack = 1'b0;
    accept();
    model_pc = model_pc + 32'd4;
    checks++; if (imem_req !== 1'b1 || imem_addr !== model_pc) begin errors++; $display("FAIL sw_next: got req %b addr %h expected 1 %h", imem_req, imem_addr, model_pc); end
  endtask

  task automatic test_branch();
    // jalr to reach 0x100; unaligned target bits must be dropped
    fetch_word(32'h0000_80E7, 0, got_addr, waited);
    wait_valid(waited);
    exp_cw = ref_cw(32'h0000_80E7, model_pc);
    checks++; if (cw_now !== exp_cw) begin errors++; $display("FAIL jalr_cw: got %h expected %h", cw_now, exp_cw); end
    accept();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0 || cw_valid !== 1'b0) begin errors++; $display("FAIL jalr_wait: got req %b valid %b expected 0 0", imem_req, cw_valid); end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    resolve(1'b1, 32'h0000_0103);
    model_pc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      fetch_word(32'h0000_0463, 0, got_addr, waited);
      checks++; if (got_addr !== model_pc || waited !== 0) begin errors++; $display("FAIL beq_fetch: got addr %h wait %0d expected %h wait 0", got_addr, waited, model_pc); end
      wait_valid(waited);
      checks++; if ({instType, imm, pc} !== {4'd6, 32'd8, model_pc}) begin errors++; $display("FAIL beq_fields: got %h expected %h", {instType, imm, pc}, {4'd6, 32'd8, model_pc}); end
      accept();
      if (k == 0) begin resolve(1'b1, 32'h0000_0108); model_pc = 32'h108; end
      else if (k == 1) begin resolve(1'b1, 32'h0000_0102); model_pc = 32'h100; end
      else begin resolve(1'b0, $urandom); model_pc = 32'h104; end
      checks++; if (imem_req !== 1'b1 || imem_addr !== model_pc) begin errors++; $display("FAIL beq_target: got req %b addr %h expected 1 %h", imem_req, imem_addr, model_pc); end
    end
  endtask

  task automatic test_lui();
    fetch_word(32'h1234_52B7, 1, got_addr, waited);
    wait_valid(waited);
    checks++; if ({instType, rd, rs1, imm} !== {4'd4, 5'd5, 5'd0, 32'h1234_5000}) begin errors++; $display("FAIL lui_fields: got %h expected %h", {instType, rd, rs1, imm}, {4'd4, 5'd5, 5'd0, 32'h1234_5000}); end
    accept();
    model_pc = model_pc + 32'd4;
  endtask

  task automatic test_jal();
    fetch_word(32'h0000_0463, 0, got_addr, waited);
    wait_valid(waited);
    accept();
    resolve(1'b1, 32'h0000_0020);
    model_pc = 32'h20;
    fetch_word(32'h0100_00EF, 0, got_addr, waited);
    checks++; if (got_addr !== 32'h20) begin errors++; $display("FAIL jal_fetch: got %h expected 00000020", got_addr); end
    wait_valid(waited);
    checks++; if ({instType, rd, imm} !== {4'd8, 5'd1, 32'd16}) begin errors++; $display("FAIL jal_fields: got %h expected %h", {instType, rd, imm}, {4'd8, 5'd1, 32'd16}); end
    accept();
    if (PREDICT) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin errors++; $display("FAIL jal_predict: got req %b addr %h expected 1 00000030", imem_req, imem_addr); end
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL jal_wait: got req %b expected 0", imem_req); end
        @(negedge clk);
      end
      resolve(1'b1, 32'h0000_0030);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin errors++; $display("FAIL jal_resolve: got req %b addr %h expected 1 00000030", imem_req, imem_addr); end
    end
    model_pc = 32'h30;
  endtask

  task automatic test_wrap();
    fetch_word(32'h0000_0463, 0, got_addr, waited);
    wait_valid(waited);
    accept();
    resolve(1'b1, 32'hFFFF_FFFE);
    fetch_word(32'h0050_0093, 0, got_addr, waited);
    checks++; if (got_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got %h expected fffffffc", got_addr); end
    wait_valid(waited);
    accept();
    model_pc = 32'h0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got req %b addr %h expected 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] r, word, tgt;
    int idx, stall;
    logic taken;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 8);
      r = $urandom;
      word = {r[31:7], OPC[idx]};
      // Inputs that must be ignored while fetching
      cw_ready = 1'($urandom);
      resolve_valid = 1'($urandom);
      resolve_taken = 1'b1;
      resolve_pc = $urandom;
      fetch_word(word, $urandom_range(0, 3), got_addr, waited);
      cw_ready = 1'b0;
      resolve_valid = 1'b0;
      checks++; if (got_addr !== model_pc || waited !== 0) begin errors++; $display("FAIL rnd_fetch: got addr %h wait %0d expected %h wait 0", got_addr, waited, model_pc); end
      wait_valid(waited);
      checks++; if (waited !== 1) begin errors++; $display("FAIL rnd_latency: got %0d expected 1", waited); end
      exp_cw = ref_cw(word, model_pc);
      checks++; if (cw_now !== exp_cw) begin errors++; $display("FAIL rnd_cw: word %h got %h expected %h", word, cw_now, exp_cw); end
      stall = $urandom_range(0, 2);
      for (int i = 0; i < stall; i++) begin
        resolve_valid = 1'($urandom);
        @(negedge clk);
        checks++; if (cw_now !== exp_cw || cw_valid !== 1'b1) begin errors++; $display("FAIL rnd_stall: got %h valid %b expected %h 1", cw_now, cw_valid, exp_cw); end
      end
      resolve_valid = 1'b0;
      accept();
      if (idx == 6 || idx == 7 || (idx == 8 && !PREDICT)) begin
        repeat ($urandom_range(0, 2)) begin
          checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_resolve_wait: got req %b expected 0", imem_req); end
          @(negedge clk);
        end
        taken = 1'($urandom);
        tgt = $urandom;
        resolve(taken, tgt);
        model_pc = taken ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
      end else if (idx == 8) begin
        model_pc = model_pc + exp_cw[31:0];
      end else begin
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic test_illegal();
    fetch_word(32'hFFFF_FFFF, 0, got_addr, waited);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checks++; if (illegal !== 1'b1 || imem_req !== 1'b0 || cw_valid !== 1'b0) begin errors++; $display("FAIL halt: got illegal %b req %b valid %b expected 1 0 0", illegal, imem_req, cw_valid); end
      imem_ack = 1'($urandom);
      cw_ready = 1'($urandom);
      resolve_valid = 1'($urandom);
      @(negedge clk);
    end
    cw_ready = 1'b0;
    resolve_valid = 1'b0;
    rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (illegal !== 1'b0 || imem_addr !== TB_RESET_PC || imem_req !== 1'b0) begin errors++; $display("FAIL halt_reset: got illegal %b addr %h req %b expected 0 %h 0", illegal, imem_addr, imem_req, TB_RESET_PC); end
    rst = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || cw_valid !== 1'b0 || imem_addr !== TB_RESET_PC) begin errors++; $display("FAIL halt_restart: got req %b valid %b addr %h expected 1 0 %h", imem_req, cw_valid, imem_addr, TB_RESET_PC); end
  endtask

  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    cw_ready = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    resolve_pc = 32'd0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_store_stall();
    test_branch();
    test_lui();
    test_jal();
    test_wrap();
    test_random();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode front end that produces the control word consumed by the core datapath. The control word is `instType`, `fun3`, `fun7`, `rd`, `rs1`, `rs2`, `pc` and `imm`. The block owns the PC, requests instruction words from instruction memory over a req/ack handshake, and decodes RV32I into the core's `instType` encoding. It issues one control word at a time over a valid/ready handshake and waits for the datapath to resolve control-flow instructions before fetching the next word.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; low two bits must be 0.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  byte address of the requested word (always equals `pc`).
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `cw_valid`  out  1  control word valid.
- `cw_ready`  in  1  datapath accepts the control word.
- `instType`  out  4  instruction class: load 0, imm 1, store 2, reg 3, lui 4, auipc 5, brnch 6, jalr 7, jal 8.
- `fun3`  out  3  instr[14:12].
- `fun7`  out  1  instr[30].
- `rd`, `rs1`, `rs2`  out  5 each  register indices.
- `pc`  out  32  address of the issued instruction.
- `imm`  out  32  sign-extended immediate.
- `resolve_valid`  in  1  datapath has resolved a brnch/jal/jalr.
- `resolve_taken`  in  1  branch/jump taken.
- `resolve_pc`  in  32  target address when taken.
- `illegal`  out  1  sticky illegal-opcode flag.

## Operation

- States: FETCH, DECODE, ISSUE, RESOLVE, HALT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ack`=1, latch `imem_rdata` and go to DECODE.
- DECODE takes one cycle. It registers all control word fields from the latched word.
  - If the opcode is not one of the nine classes, go to HALT.
  - Otherwise go to ISSUE.
- ISSUE:
  - `cw_valid`=1, with all fields held stable until the handshake.
  - On an edge with `cw_valid`&&`cw_ready`, the next state depends on class.
  - brnch, jalr: go to RESOLVE.
  - jal: go to RESOLVE, unless `FD_JAL_PREDICT_EN` is defined (see Configuration).
  - All other classes: `pc`←`pc`+4 (mod 2^32) and go to FETCH.
- RESOLVE:
  - Wait for `resolve_valid`.
  - Then `pc`←`resolve_taken` ? {`resolve_pc`[31:2],2'b00} : `pc`+4, and go to FETCH.
- HALT: `illegal`=1, no requests, no issue. Only reset exits HALT.
- Field rules:
  - `rd`=0 for store and brnch.
  - `rs1`=0 for lui, auipc and jal. lui therefore yields x0+imm.
  - `rs2`=0 for every class except reg, store and brnch.
  - `fun7`=instr[30] for reg, and for imm with `fun3`=001 or 101; 0 otherwise.
  - `fun3`=0 for lui, auipc and jal.
- Immediates:
  - I-type: load, imm, jalr.
  - S-type: store.
  - B-type: brnch, with bit 0 = 0.
  - U-type: lui, auipc, {instr[31:12],12'b0}.
  - J-type: jal, with bit 0 = 0.
  - All are sign-extended from instr[31].
  - reg: `imm`=0.

## Timing

- Reset values:
  - State FETCH, `pc`=`RESET_PC`.
  - `imem_req`=0, `cw_valid`=0, `illegal`=0.
  - All control word fields 0.
- `imem_req` first rises in the cycle after the edge where `rst` is sampled high.
- With single-cycle `imem_ack` and `cw_ready` held high:
  - Non-control instructions take 3 cycles each (FETCH, DECODE, ISSUE).
  - Control-flow instructions take ≥4 cycles.
- Boundary conditions:
  - `imem_ack` outside FETCH is ignored.
  - `resolve_valid` outside RESOLVE is ignored.
  - `cw_ready` while `cw_valid`=0 is ignored.
- `pc`+4 at 32'hFFFF_FFFC wraps to 0.
- Reset asserted in any state returns to reset values on that edge. An ack arriving in the same cycle is dropped.
- `imem_req`, `cw_valid` and all control word outputs are driven from registers; no combinational path from inputs.

## Configuration

- `FD_JAL_PREDICT_EN` defined:
  - jal computes its target locally: after the ISSUE handshake, `pc`←`pc`+`imm` and go directly to FETCH, skipping RESOLVE.
  - `resolve_*` inputs are ignored for jal.
  - jal still issues to the datapath, which writes the link register.
- `FD_JAL_PREDICT_EN` undefined: jal waits in RESOLVE like jalr.

## Test plan

- Reset with `RESET_PC`=0, fetch returns 0x00500093 (addi x1,x0,5).
  - Required: instType=1, rd=1, rs1=0, fun3=0, imm=5, `cw_valid` in 3rd cycle after ack request.
  - Next `imem_addr`=0x4.
- Fetch 0x0020A423 (sw x2,8(x1)).
  - Required: instType=2, rs1=1, rs2=2, rd=0, imm=8.
  - Hold `cw_ready`=0 for 5 cycles; fields must stay stable and no new `imem_req` may appear.
- At pc=0x100, fetch 0x00000463 (beq x0,x0,8).
  - Required: instType=6, imm=8.
  - With resolve taken=1, `resolve_pc`=0x108: next `imem_addr`=0x108.
  - With taken=0: next `imem_addr`=0x104.
- Fetch 0x123452B7 (lui x5,0x12345).
  - Required: instType=4, rd=5, rs1=0, imm=0x12345000.
- Fetch 0xFFFFFFFF.
  - Required: `illegal`=1, `imem_req` and `cw_valid` stay 0 indefinitely.
  - Then `rst`=0 for one edge: `illegal`=0, `imem_addr`=`RESET_PC`.
- At pc=0x20, fetch 0x010000EF (jal x1,16).
  - Required: instType=8, imm=16.
  - With `FD_JAL_PREDICT_EN` defined: next fetch at 0x30 without `resolve_valid`.
  - Without it: no fetch until `resolve_valid`.
